m_stage_sched: RTL and testbench
================================

// Module: m_stage_sched
// PURPOSE
//  SHA-256 message-schedule producer; the feeding end of the round stage's k/w (in8/in9) inputs.
//  Accepts one 512-bit block as 16 big-endian 32-bit words over a valid/ready input stream.
//  Emits 64 (w_t, K_t) pairs over a valid/ready output stream, one pair per handshake, t = 0..63.
//  Sits between the Versat memory/unit fabric and the round stage, inside the SHA-256 datapath.
// PARAMETERS
//  DATA_W   32  word width; only 32 is supported; any other value is an elaboration error
//  ROUNDS   64  pairs emitted per block
// PORTS
//  clk        in   1       single clock; all state updates on posedge
//  rst        in   1       asynchronous, active-low reset (asserted at 0)
//  run        in   1       start pulse; honoured only in IDLE
//  in_valid   in   1       in_data is valid
//  in_ready   out  1       block accepts a word
//  in_data    in   DATA_W  message word, big-endian order, M0 first
//  out_valid  out  1       out_w/out_k/out_round are valid
//  out_ready  in   1       consumer accepts the pair
//  out_w      out  DATA_W  w_t
//  out_k      out  DATA_W  K_t
//  out_round  out  6       t
//  out_last   out  1       out_valid && t==63
//  busy       out  1       state != IDLE
//  done       out  1       one-cycle pulse after the t=63 handshake
// BEHAVIOUR
//  Reset (rst=0): state=IDLE, window W[0..15]=0, cnt=0, all outputs 0.
//  FSM IDLE -> LOAD on run; LOAD -> STREAM on the 16th input handshake; STREAM -> IDLE on the t=63 output handshake.
//  Side effect of STREAM -> IDLE: done=1 for exactly that next cycle.
//  IDLE: in_ready=0, out_valid=0; run=1 clears cnt to 0.
//  LOAD: in_ready=1, out_valid=0.
//    Each in handshake: W[i]<=W[i+1] for i<15, W[15]<=in_data, cnt++.
//    On cnt==15 with a handshake: cnt<=0, go STREAM.
//  STREAM: in_ready=0, out_valid=1.
//    Outputs are driven straight from registers: out_w=W[0], out_k=K[cnt], out_round=cnt.
//    Each out handshake: W[i]<=W[i+1];
//    W[15]<=s1(W[14])+W[9]+s0(W[1])+W[0], mod 2^32 (carries dropped).
//    s0(x)=ROTR7^ROTR18^SHR3; s1(x)=ROTR17^ROTR19^SHR10.
//    On cnt==63 with a handshake: go IDLE.
//  Latency: first out_valid is 1 cycle after the 16th in handshake.
//    Throughput is 1 pair/cycle while out_ready=1.
//  Backpressure: with out_ready=0, all outputs hold stable and W/cnt are frozen.
//  run asserted while busy is ignored; no restart mid-block.
//  in_valid outside LOAD is ignored; no word is consumed.
//  rst=0 mid-LOAD or mid-STREAM aborts immediately to the reset state; partial data is discarded, no done.
//  done and run in the same cycle: the FSM is in IDLE, so run is honoured.
// CONFIGURATION
//  M_STAGE_BSWAP_EN defined:
//    in_data is byte-swapped on capture ({b0,b1,b2,b3}), for little-endian memory images.
//  M_STAGE_BSWAP_EN undefined:
//    in_data is captured unchanged.
//  All other behaviour is identical in both builds.
// STRUCTURE
//  Shared package sha256_pkg:
//    SHA256_K[0:63] constant table.
//    State encoding localparams IDLE/LOAD/STREAM.
//    sigma0/sigma1 functions, shared with Comb_F_Stage's Sigma functions.
//  One sub-module: m_stage_sigma (combinational s0/s1 + 4-input adder), keeps this file to FSM+window.
// TESTING
//  1 "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), out_ready=1:
//    t0 w=0x61626380 k=0x428a2f98; t16 w=0x61626380; t17 w=0x000f0000;
//    t63 w=0x12b1edeb k=0xc67178f2; done 1 cycle after.
//  2 Same block, out_ready toggled 1/0 every cycle:
//    identical 64 pairs; outputs stable while stalled; done after 128 cycles of STREAM.
//  3 in_valid gapped (1 word per 3 cycles):
//    in_ready stays 1; STREAM starts exactly 1 cycle after the 16th word.
//  4 run pulsed at t=10 of STREAM and in_valid=1 during STREAM:
//    no effect; sequence unchanged.
//  5 rst=0 at t=30, released, then new run + "abc" block:
//    outputs 0 during reset; fresh t0 w=0x61626380; no done from the aborted block.
//  6 M_STAGE_BSWAP_EN build, W0 presented as 0x80636261:
//    t0 w=0x61626380; all other checks as in scenario 1.

Source files
------------

// File: rtl/sha256_pkg.sv
// sha256_pkg
//   Shared definitions for the SHA-256 datapath.
//   - state_t       : message-schedule FSM encoding (IDLE / LOAD / STREAM)
//   - SHA256_K      : 64-entry round-constant table
//   - sigma0/sigma1 : message-schedule small sigma functions
//   - big_sigma0/1  : compression-round Sigma functions (used by the round stage)
package sha256_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } state_t;

  localparam int unsigned SHA_WORD_W = 32;
  localparam int unsigned SHA_WIN_N  = 16;

  localparam logic [31:0] SHA256_K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

endpackage

// File: rtl/m_stage_sigma.sv
// m_stage_sigma
//   Combinational next-word generator for the SHA-256 message schedule:
//     o_next = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16]  (mod 2^32)
//   Expressed against a 16-word window whose oldest entry is index 0.
// Ports
//   i_w0   in  32  window[0]  (W[t-16])
//   i_w1   in  32  window[1]  (W[t-15])
//   i_w9   in  32  window[9]  (W[t-7])
//   i_w14  in  32  window[14] (W[t-2])
//   o_next out 32  W[t]
module m_stage_sigma
  import sha256_pkg::*;
(
  input  logic [31:0] i_w0,
  input  logic [31:0] i_w1,
  input  logic [31:0] i_w9,
  input  logic [31:0] i_w14,
  output logic [31:0] o_next
);

  logic [31:0] w_s0;
  logic [31:0] w_s1;

  assign w_s0   = sigma0(i_w1);
  assign w_s1   = sigma1(i_w14);
  // 32-bit sum: carries out of bit 31 are dropped by the result width.
  assign o_next = w_s1 + i_w9 + w_s0 + i_w0;

endmodule

// File: rtl/m_stage_sched.sv
// m_stage_sched
//   SHA-256 message-schedule producer. Loads one 512-bit block as 16 32-bit
//   words (M0 first) and then streams the 64 (w_t, K_t) pairs to the round
//   stage.
//
//   Handshakes: a transfer happens on a rising clk edge where both valid and
//   ready are 1. The producer holds valid and data stable until the transfer;
//   ready may change freely. in_ready is 1 exactly in LOAD, out_valid is 1
//   exactly in STREAM.
//
//   Build option: define M_STAGE_BSWAP_EN to byte-swap each in_data word on
//   capture (little-endian memory images). Undefined: captured unchanged.
//
// Ports
//   clk        in   1       clock, rising edge
//   rst        in   1       asynchronous active-low reset
//   run        in   1       start pulse, honoured only in IDLE
//   in_valid   in   1       in_data valid
//   in_ready   out  1       accepting a message word (LOAD)
//   in_data    in   DATA_W  message word
//   out_valid  out  1       out_w/out_k/out_round valid (STREAM)
//   out_ready  in   1       consumer takes the pair
//   out_w      out  DATA_W  w_t
//   out_k      out  DATA_W  K_t
//   out_round  out  6       t
//   out_last   out  1       out_valid && t == ROUNDS-1
//   busy       out  1       state != IDLE
//   done       out  1       one-cycle pulse after the last pair handshake
//   dbg_state  out  2       current FSM state (state_t encoding)
module m_stage_sched
  import sha256_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ROUNDS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_w,
  output logic [DATA_W-1:0] out_k,
  output logic [5:0]        out_round,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  if (DATA_W != 32) begin : g_width_check
    $error("m_stage_sched: DATA_W must be 32");
  end

  localparam logic [5:0] LAST_T    = 6'(ROUNDS - 1);
  localparam logic [5:0] LAST_WORD = 6'(SHA_WIN_N - 1);

  state_t      r_state;
  logic [31:0] r_win [0:15];
  logic [5:0]  r_cnt;
  logic        r_done;

  logic [31:0] w_capture;
  logic [31:0] w_next_w;
  logic        w_streaming;

`ifdef M_STAGE_BSWAP_EN
  assign w_capture = {in_data[7:0], in_data[15:8], in_data[23:16], in_data[31:24]};
`else
  assign w_capture = in_data;
`endif

  m_stage_sigma u_sigma (
    .i_w0   (r_win[0]),
    .i_w1   (r_win[1]),
    .i_w9   (r_win[9]),
    .i_w14  (r_win[14]),
    .o_next (w_next_w)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        r_win[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (run) begin
            r_cnt   <= '0;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (in_valid) begin
            for (int i = 0; i < 15; i++) begin
              r_win[i] <= r_win[i+1];
            end
            r_win[15] <= w_capture;
            if (r_cnt == LAST_WORD) begin
              r_cnt   <= '0;
              r_state <= STREAM;
            end else begin
              r_cnt <= r_cnt + 6'd1;
            end
          end
        end
        STREAM: begin
          // A stalled consumer freezes the window and counter, so the
          // presented pair stays stable until it is taken.
          if (out_ready) begin
            for (int i = 0; i < 15; i++) begin
              r_win[i] <= r_win[i+1];
            end
            r_win[15] <= w_next_w;
            if (r_cnt == LAST_T) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 6'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_streaming = (r_state == STREAM);

  assign in_ready  = (r_state == LOAD);
  assign out_valid = w_streaming;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign dbg_state = r_state;

  // Data outputs are forced to 0 outside STREAM so that a finished window or
  // the LOAD word counter never leaks onto the round-stage inputs.
  assign out_w     = w_streaming ? r_win[0]        : '0;
  assign out_k     = w_streaming ? SHA256_K[r_cnt] : '0;
  assign out_round = w_streaming ? r_cnt           : '0;
  assign out_last  = w_streaming && (r_cnt == LAST_T);

endmodule

// File: tb/tb_m_stage_sched.sv
module tb_m_stage_sched;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_w;
  logic [31:0] out_k;
  logic [5:0]  out_round;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  m_stage_sched #(.DATA_W(32), .ROUNDS(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_w     (out_w),
    .out_k     (out_k),
    .out_round (out_round),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  logic        abc_mode = 1'b0;
  logic [70:0] exp_q[$];
  logic [31:0] cur_blk [0:15];

  localparam logic [31:0] TB_K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] ms0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] ms1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ {10'b0, x[31:10]};
  endfunction

  task automatic push_expected();
    logic [31:0] w [0:63];
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = cur_blk[t];
      else        w[t] = ms1(w[t-2]) + w[t-7] + ms0(w[t-15]) + w[t-16];
      exp_q.push_back({6'(t), (t == 63), w[t], TB_K[t]});
    end
  endtask

  function automatic logic [31:0] drv_word(input logic [31:0] x);
`ifdef M_STAGE_BSWAP_EN
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
    return x;
`endif
  endfunction

  task automatic set_abc();
    for (int i = 0; i < 16; i++) cur_blk[i] = 32'h0;
    cur_blk[0]  = 32'h61626380;
    cur_blk[15] = 32'h00000018;
    abc_mode = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic        stall_prev = 1'b0;
  logic [70:0] held = '0;

  always @(negedge clk) begin
    logic [70:0] act;
    logic [70:0] exp;
    if (rst) begin
      act = {out_round, out_last, out_w, out_k};
      if (stall_prev) check("stall_hold", 96'(act), 96'(held));
      stall_prev = out_valid && !out_ready;
      held = act;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pair: got %h expected none", act);
        end else begin
          exp = exp_q.pop_front();
          check("pair", 96'(act), 96'(exp));
          if (abc_mode) begin
            case (out_round)
              6'd0: begin
                check("abc_t0_w", 96'(out_w), 96'(32'h61626380));
                check("abc_t0_k", 96'(out_k), 96'(32'h428a2f98));
              end
              6'd16: check("abc_t16_w", 96'(out_w), 96'(32'h61626380));
              6'd17: check("abc_t17_w", 96'(out_w), 96'(32'h000f0000));
              6'd63: begin
                check("abc_t63_w", 96'(out_w), 96'(32'h12b1edeb));
                check("abc_t63_k", 96'(out_k), 96'(32'hc67178f2));
              end
              default: ;
            endcase
          end
        end
      end
      if (done) done_cnt++;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // ---------------- driver ----------------
  // gap: idle cycles between words; toggle: out_ready 0/1 alternating;
  // inject: run pulse and in_valid noise during STREAM; abort_t: reset at
  // that STREAM cycle (-1 = none).
  task automatic run_block(input int gap, input bit toggle, input bit inject, input int abort_t);
    int n;
    bit got_done;
    int dc;
    push_expected();
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    check("busy_in_load", 96'(busy), 96'(1));
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = drv_word(cur_blk[i]);
      @(negedge clk);
      check("load_ready", 96'(in_ready), 96'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (i < 15) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          check("gap_ready", 96'(in_ready), 96'(1));
          @(posedge clk); #1;
        end
      end
    end
    check("first_valid", 96'({out_valid, in_ready}), 96'(2'b10));
    out_ready = toggle ? 1'b0 : 1'b1;
    n = 0;
    got_done = 1'b0;
    while (n < 300 && !got_done) begin
      if (inject) begin
        in_valid = 1'b1;
        in_data  = $urandom;
        run      = (n == 10);
      end
      if (abort_t >= 0 && n == abort_t) break;
      @(posedge clk); #1;
      n++;
      if (done) got_done = 1'b1;
      else      out_ready = toggle ? ~out_ready : 1'b1;
    end
    run = 1'b0;
    in_valid = 1'b0;
    if (abort_t >= 0) begin
      dc = done_cnt;
      rst = 1'b0;
      #1;
      check("abort_outputs_zero",
            96'({out_valid, in_ready, busy, done, out_last, out_round, out_w, out_k}), 96'(0));
      repeat (3) @(posedge clk);
      #1;
      check("abort_hold_zero", 96'({out_valid, busy, out_w, out_k}), 96'(0));
      rst = 1'b1;
      exp_q.delete();
      repeat (4) @(posedge clk);
      #1;
      check("abort_no_done", 96'(done_cnt), 96'(dc));
      check("abort_idle", 96'(busy), 96'(0));
      out_ready = 1'b1;
    end else begin
      check("done_seen", 96'(got_done), 96'(1));
      check("done_latency", 96'(n), toggle ? 96'(128) : 96'(64));
      check("idle_after_done", 96'({busy, out_valid, in_ready}), 96'(0));
      @(posedge clk); #1;
      check("done_one_cycle", 96'(done), 96'(0));
      check("queue_empty", 96'(exp_q.size()), 96'(0));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          96'({out_valid, in_ready, busy, done, out_last, out_round, out_w, out_k}), 96'(0));
    rst = 1'b1;
    @(posedge clk); #1;

    // in_valid in IDLE must not be accepted
    in_valid = 1'b1;
    in_data  = 32'hdeadbeef;
    repeat (3) begin
      @(negedge clk);
      check("idle_ignores_in", 96'({in_ready, busy}), 96'(0));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    // 1: abc block, consumer always ready
    set_abc();
    run_block(0, 1'b0, 1'b0, -1);
    // 2: same block, out_ready toggling
    run_block(0, 1'b0 | 1'b0, 1'b0, -1) ;
    set_abc();
    run_block(0, 1'b1, 1'b0, -1);
    // 3: different block, one word every 3 cycles
    for (int i = 0; i < 16; i++) cur_blk[i] = 32'h01234567 + 32'(i) * 32'h11111111;
    abc_mode = 1'b0;
    run_block(2, 1'b0, 1'b0, -1);
    // 4: run and in_valid noise during STREAM
    set_abc();
    run_block(0, 1'b0, 1'b1, -1);
    // 5: reset at t=30, then a fresh abc block
    run_block(0, 1'b0, 1'b0, 30);
    set_abc();
    run_block(0, 1'b0, 1'b0, -1);

    check("total_done_pulses", 96'(done_cnt), 96'(6));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
